// File: rtl/instr_pair_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_pair_queue
// Brief    : Dual-lane fetch->decode instruction pair FIFO with flush.
//            Optional push->pop bypass when INSTR_PAIR_QUEUE_BYPASS_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
module instr_pair_queue #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic                    push_valid,
    output logic                    push_ready,
    input  logic [DATA_WIDTH-1:0]   push_pc,
    input  logic [DATA_WIDTH-1:0]   push_instrA,
    input  logic [DATA_WIDTH-1:0]   push_instrB,
    input  logic                    push_b_valid,
    output logic                    pop_valid,
    input  logic                    pop_ready,
    output logic [DATA_WIDTH-1:0]   pop_pc,
    output logic [DATA_WIDTH-1:0]   pop_instrA,
    output logic [DATA_WIDTH-1:0]   pop_instrB,
    output logic                    pop_b_valid,
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [DATA_WIDTH-1:0] C_NOP  = DATA_WIDTH'(32'h0000_0013);
    localparam logic [CW-1:0]         C_FULL = CW'(DEPTH);

    logic [DATA_WIDTH-1:0] pc_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] ia_mem_q [DEPTH];
    logic [DATA_WIDTH-1:0] ib_mem_q [DEPTH];
    logic                  bv_mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q,  count_d;

    logic w_not_empty;
    logic w_bypass;
    logic w_push;
    logic w_pop;
    logic w_wr_en;
    logic w_rd_en;

    // Full-state comparison only: a pop never opens a slot in the same cycle.
    assign push_ready  = rst && !flush && (count_q < C_FULL);
    assign w_not_empty = rst && (count_q != '0);

`ifdef INSTR_PAIR_QUEUE_BYPASS_EN
    assign w_bypass = rst && !flush && (count_q == '0) && push_valid;
`else
    assign w_bypass = 1'b0;
`endif

    assign pop_valid = w_not_empty || w_bypass;
    assign w_push    = push_valid && push_ready;
    assign w_pop     = pop_valid && pop_ready;
    // A bypassed pair that decode takes immediately is never written.
    assign w_wr_en   = w_push && !(w_bypass && pop_ready);
    assign w_rd_en   = w_pop && !w_bypass;
    assign count     = count_q;

    always_comb begin
        pop_pc      = '0;
        pop_instrA  = C_NOP;
        pop_instrB  = C_NOP;
        pop_b_valid = 1'b0;
        if (w_not_empty) begin
            pop_pc      = pc_mem_q[rd_ptr_q];
            pop_instrA  = ia_mem_q[rd_ptr_q];
            pop_b_valid = bv_mem_q[rd_ptr_q];
            pop_instrB  = bv_mem_q[rd_ptr_q] ? ib_mem_q[rd_ptr_q] : C_NOP;
        end else if (w_bypass) begin
            pop_pc      = push_pc;
            pop_instrA  = push_instrA;
            pop_b_valid = push_b_valid;
            pop_instrB  = push_b_valid ? push_instrB : C_NOP;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_wr_en) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_rd_en) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end
        count_d = count_q + CW'(w_wr_en) - CW'(w_rd_en);
    end

    always_ff @(posedge clk) begin
        if (!rst || flush) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage carries no reset; validity lives entirely in count_q.
    always_ff @(posedge clk) begin
        if (rst && !flush && w_wr_en) begin
            pc_mem_q[wr_ptr_q] <= push_pc;
            ia_mem_q[wr_ptr_q] <= push_instrA;
            ib_mem_q[wr_ptr_q] <= push_instrB;
            bv_mem_q[wr_ptr_q] <= push_b_valid;
        end
    end

`ifndef SYNTHESIS
    always_ff @(posedge clk) begin
        if (rst && !flush) begin
            assert (count_q <= C_FULL)
                else $error("instr_pair_queue: count above DEPTH");
            assert (!(w_rd_en && count_q == '0))
                else $error("instr_pair_queue: pop from empty queue");
            assert (!(w_wr_en && count_q == C_FULL))
                else $error("instr_pair_queue: push into full queue");
        end
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_pair_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_pair_queue
// Brief    : Self-checking bench for instr_pair_queue against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_pair_queue;

    localparam int DW    = 32;
    localparam int DEPTH = 4;
    localparam logic [31:0] NOP = 32'h0000_0013;
`ifdef INSTR_PAIR_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] a;
        logic [31:0] b;
        logic        bv;
    } pair_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          flush = 1'b0;
    logic          push_valid = 1'b0;
    logic          push_ready;
    logic [DW-1:0] push_pc = '0;
    logic [DW-1:0] push_instrA = '0;
    logic [DW-1:0] push_instrB = '0;
    logic          push_b_valid = 1'b0;
    logic          pop_valid;
    logic          pop_ready = 1'b0;
    logic [DW-1:0] pop_pc;
    logic [DW-1:0] pop_instrA;
    logic [DW-1:0] pop_instrB;
    logic          pop_b_valid;
    logic [$clog2(DEPTH):0] count;

    int checks = 0;
    int errors = 0;
    pair_t q[$];
    logic [31:0] obs_pc;

    always #5 clk = ~clk;

    instr_pair_queue #(.DATA_WIDTH(DW), .DEPTH(DEPTH)) dut (
        .clk          (clk),
        .rst          (rst),
        .flush        (flush),
        .push_valid   (push_valid),
        .push_ready   (push_ready),
        .push_pc      (push_pc),
        .push_instrA  (push_instrA),
        .push_instrB  (push_instrB),
        .push_b_valid (push_b_valid),
        .pop_valid    (pop_valid),
        .pop_ready    (pop_ready),
        .pop_pc       (pop_pc),
        .pop_instrA   (pop_instrA),
        .pop_instrB   (pop_instrB),
        .pop_b_valid  (pop_b_valid),
        .count        (count)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive, compare against the model, advance the model.
    task automatic step(input logic r, input logic f, input logic pv, input logic pr,
                        input logic [31:0] pc, input logic [31:0] a, input logic [31:0] b,
                        input logic bv, input bit en);
        pair_t h;
        bit    byp, e_pr, e_pv;
        rst = r; flush = f; push_valid = pv; pop_ready = pr;
        push_pc = pc; push_instrA = a; push_instrB = b; push_b_valid = bv;
        #3;
        byp  = BYP && r && !f && (q.size() == 0) && pv;
        e_pr = r && !f && (q.size() < DEPTH);
        e_pv = (r && q.size() != 0) || byp;
        if (r && q.size() != 0) h = q[0];
        else                    h = '{pc: pc, a: a, b: b, bv: bv};
        obs_pc = pop_pc;
        if (en) begin
            chk("count",       32'(count),       32'(q.size()));
            chk("push_ready",  32'(push_ready),  32'(e_pr));
            chk("pop_valid",   32'(pop_valid),   32'(e_pv));
            chk("pop_pc",      pop_pc,           e_pv ? h.pc : 32'h0);
            chk("pop_instrA",  pop_instrA,       e_pv ? h.a : NOP);
            chk("pop_b_valid", 32'(pop_b_valid), 32'(e_pv && h.bv));
            chk("pop_instrB",  pop_instrB,       (e_pv && h.bv) ? h.b : NOP);
        end
        @(posedge clk);
        if (!r || f) begin
            q.delete();
        end else if (!(byp && pr)) begin
            if (e_pv && pr) void'(q.pop_front());
            if (pv && e_pr) q.push_back('{pc: pc, a: a, b: b, bv: bv});
        end
        #1;
    endtask

    task automatic push1(input logic [31:0] pc, input logic pr);
        step(1'b1, 1'b0, 1'b1, pr, pc, $urandom, $urandom, 1'b1, 1'b1);
    endtask

    task automatic idle(input logic pr);
        step(1'b1, 1'b0, 1'b0, pr, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 2 && q.size() != 0; i++) idle(1'b1);
        chk("drained", 32'(q.size()), 32'h0);
    endtask

    initial begin
        // Reset hold with fetch offering pairs.
        step(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, $urandom, $urandom, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++)
            step(1'b0, 1'b0, 1'b1, 1'b0, 32'h40, $urandom, $urandom, 1'b1, 1'b1);
        idle(1'b0);

        // Fill then drain in order.
        for (int i = 0; i < DEPTH; i++) push1(32'(i * 8), 1'b0);
        push1(32'h100, 1'b0);
        chk("full_count", 32'(count), 32'(DEPTH));
        for (int i = 0; i < DEPTH; i++) begin
            idle(1'b1);
            chk("drain_order", obs_pc, 32'(i * 8));
        end
        idle(1'b0);

        // Streaming with simultaneous push and pop across pointer wrap.
        for (int i = 0; i < 20; i++) push1(32'h1000 + 32'(i * 8), 1'b1);
        chk("stream_count", 32'(count), BYP ? 32'h0 : 32'h1);
        drain();

        // Flush with simultaneous push and pop.
        for (int i = 0; i < 3; i++) push1(32'h2000 + 32'(i * 8), 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'hBAD0, $urandom, $urandom, 1'b1, 1'b1);
        idle(1'b0);
        idle(1'b1);

        // Lane-B bubble keeps instrB hidden.
        step(1'b1, 1'b0, 1'b1, 1'b0, 32'h3000, 32'h1111_2222, 32'hDEAD_BEEF, 1'b0, 1'b1);
        idle(1'b1);
        chk("bubble_pc", obs_pc, 32'h3000);

        // Backpressure: head must stay put while pushes fill the queue.
        push1(32'h4000, 1'b0);
        for (int i = 0; i < 5; i++) begin
            push1(32'h4008 + 32'(i * 8), 1'b0);
            chk("hold_pc", obs_pc, 32'h4000);
        end
        chk("bp_full", 32'(count), 32'(DEPTH));

        // Reset mid-operation behaves like flush.
        step(1'b0, 1'b0, 1'b1, 1'b1, 32'h5000, $urandom, $urandom, 1'b1, 1'b1);
        idle(1'b0);

        // Randomized traffic with occasional flush and reset.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 49) != 0), ($urandom_range(0, 24) == 0),
                 ($urandom_range(0, 3) != 0), 1'($urandom),
                 $urandom, $urandom, $urandom, 1'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
